rl_fifo_burst_rd: RTL

RL_FIFO_BURST_RD -- requirements
Module: rl_fifo_burst_rd

---
 rtl/rl_fifo_pkg.sv | 16 +
 rtl/rl_fifo_burst_rd_tmr.sv | 31 +++
 rtl/rl_fifo_burst_rd.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rl_fifo_pkg.sv
// Shared types for the FIFO burst reader.
package rl_fifo_pkg;

  // Reader FSM states; FLUSH is only reachable with RL_FIFO_BURST_RD_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } rd_state_e;

  // True while the reader is draining words from the FIFO
  function automatic logic is_draining(rd_state_e s);
    return (s == ST_BURST) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/rl_fifo_burst_rd_tmr.sv
// Idle timeout counter for partial-burst flushing.
// Instantiated only when RL_FIFO_BURST_RD_TIMEOUT_EN is defined.
module rl_fifo_burst_rd_tmr #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic tmo_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Strobe on the TIMEOUT_CYCLES-th consecutive qualifying cycle
  assign tmo_o = cnt_en_i & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count qualifying cycles; any break in qualification restarts the count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || !cnt_en_i || tmo_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rl_fifo_burst_rd.sv
// Burst reader: drains a show-ahead FIFO into a valid/ready stream in
// fixed-length bursts. Define RL_FIFO_BURST_RD_TIMEOUT_EN to flush partial
// bursts after TIMEOUT_CYCLES idle cycles.
module rl_fifo_burst_rd
  import rl_fifo_pkg::*;
#(
  parameter  int unsigned DATA_SIZE      = 32,
  parameter  int unsigned FIFO_DEPTH     = 16,
  parameter  int unsigned BURST_LEN      = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned PTR_SIZE       = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic [DATA_SIZE-1:0] fifo_q_i,
  input  logic                 fifo_empty_i,
  input  logic [PTR_SIZE:0]    fifo_usedw_i,
  output logic                 fifo_rdena_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DATA_SIZE-1:0] m_data_o,
  output logic                 m_last_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = PTR_SIZE + 1;

  rd_state_e            state_q;
  logic [CNT_W-1:0]     beats_q;
  logic                 m_valid_q;
  logic                 m_last_q;
  logic [DATA_SIZE-1:0] m_data_q;

  logic pop_c;
  logic burst_rdy_c;
  logic tmo_c;

  // A full burst is available in the FIFO
  assign burst_rdy_c = (fifo_usedw_i >= CNT_W'(BURST_LEN));

  // Pop when draining, data present, output slot free or freeing, beats left
  assign pop_c = is_draining(state_q) & ~fifo_empty_i & (~m_valid_q | m_ready_i)
               & ~clr_i & (beats_q != '0);

`ifdef RL_FIFO_BURST_RD_TIMEOUT_EN
  logic tmo_en_c;

  // Timer runs only while idle with a partial burst waiting
  assign tmo_en_c = (state_q == ST_IDLE) & ~fifo_empty_i & ~burst_rdy_c;

  rl_fifo_burst_rd_tmr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clr_i),
    .cnt_en_i (tmo_en_c),
    .tmo_o    (tmo_c)
  );
`else
  // No timeout: partial bursts wait for a full burst; TIMEOUT_CYCLES is inert
  localparam bit TMO_CFG_OK = (TIMEOUT_CYCLES >= 1);
  assign tmo_c = 1'b0 & TMO_CFG_OK;
`endif

  // Burst FSM, beat counter and registered stream output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      beats_q   <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else if (clr_i) begin
      state_q   <= ST_IDLE;
      beats_q   <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (burst_rdy_c) begin
            state_q <= ST_BURST;
            beats_q <= CNT_W'(BURST_LEN);
          end else if (tmo_c) begin
            state_q <= ST_FLUSH;
            beats_q <= fifo_usedw_i;
          end
        end
        ST_BURST, ST_FLUSH: begin
          if (pop_c) begin
            beats_q <= beats_q - CNT_W'(1);
            if (beats_q == CNT_W'(1)) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (pop_c) begin
        m_valid_q <= 1'b1;
        m_data_q  <= fifo_q_i;
        m_last_q  <= (beats_q == CNT_W'(1));
      end else if (m_valid_q && m_ready_i) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  assign fifo_rdena_o = pop_c;
  assign m_valid_o    = m_valid_q;
  assign m_data_o     = m_data_q;
  assign m_last_o     = m_last_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule
